// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-port memory between the fetch stage
// (IF, read-only) and the memory stage (DM, read/write). One access is in
// flight at a time; DM has priority unless the optional fairness logic
// (macro ARB_FAIR_EN) forces an IF win after STARVE_MAX consecutive DM wins.
// Requesters are expected to update or drop their request in the cycle
// their done/err pulse is visible, since the next arbitration decision is
// taken in that same cycle.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [2:0]    dm_type,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_type,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

  state_t          state_reg, state_next;
  logic            mem_req_reg, mem_req_next;
  logic            mem_we_reg, mem_we_next;
  logic [AW-1:0]   mem_addr_reg, mem_addr_next;
  logic [DW-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [2:0]      mem_type_reg, mem_type_next;
  logic            if_gnt_reg, if_gnt_next;
  logic            if_done_reg, if_done_next;
  logic [DW-1:0]   if_rdata_reg, if_rdata_next;
  logic            dm_gnt_reg, dm_gnt_next;
  logic            dm_done_reg, dm_done_next;
  logic [DW-1:0]   dm_rdata_reg, dm_rdata_next;
  logic            dm_err_reg, dm_err_next;
  logic            dm_bad;
  logic            if_first;

`ifdef ARB_FAIR_EN
  logic [2:0]      starve_reg, starve_next;
  logic            starved;

  // IF overrides DM once DM has won STARVE_MAX times in a row against it
  assign starved  = (starve_reg == 3'(STARVE_MAX));
  assign if_first = if_req & (~dm_req | starved);
`else
  logic            unused_starve_max;

  assign unused_starve_max = (STARVE_MAX != 0);
  assign if_first          = if_req & ~dm_req;
`endif

  // Access-size check: misaligned word/half or an undefined type code
  always_comb begin
    case (dm_type)
      3'b000:         dm_bad = (dm_addr[1:0] != 2'b00);
      3'b001, 3'b010: dm_bad = dm_addr[0];
      3'b011, 3'b100: dm_bad = 1'b0;
      default:        dm_bad = 1'b1;
    endcase
  end

  // Next-state and next-output logic; pulses default low, data holds
  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_type_next  = mem_type_reg;
    if_gnt_next    = 1'b0;
    if_done_next   = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_gnt_next    = 1'b0;
    dm_done_next   = 1'b0;
    dm_rdata_next  = dm_rdata_reg;
    dm_err_next    = 1'b0;
`ifdef ARB_FAIR_EN
    starve_next    = starve_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (dm_req && !if_first) begin
          if (dm_bad) begin
            state_next  = ERR;
            dm_err_next = 1'b1;
          end else begin
            state_next     = BUSY_D;
            mem_req_next   = 1'b1;
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            mem_type_next  = dm_type;
            dm_gnt_next    = 1'b1;
`ifdef ARB_FAIR_EN
            if (if_req) begin
              starve_next = starve_reg + 3'd1;
            end
`endif
          end
        end else if (if_req) begin
          state_next     = BUSY_I;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          mem_type_next  = 3'b000;
          if_gnt_next    = 1'b1;
`ifdef ARB_FAIR_EN
          starve_next    = 3'd0;
`endif
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_next    = IDLE;
          mem_req_next  = 1'b0;
          if_rdata_next = mem_rdata;
          if_done_next  = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          dm_done_next = 1'b1;
          if (!mem_we_reg) begin
            dm_rdata_next = mem_rdata;
          end
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_type_reg  <= 3'b000;
      if_gnt_reg    <= 1'b0;
      if_done_reg   <= 1'b0;
      if_rdata_reg  <= '0;
      dm_gnt_reg    <= 1'b0;
      dm_done_reg   <= 1'b0;
      dm_rdata_reg  <= '0;
      dm_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_type_reg  <= mem_type_next;
      if_gnt_reg    <= if_gnt_next;
      if_done_reg   <= if_done_next;
      if_rdata_reg  <= if_rdata_next;
      dm_gnt_reg    <= dm_gnt_next;
      dm_done_reg   <= dm_done_next;
      dm_rdata_reg  <= dm_rdata_next;
      dm_err_reg    <= dm_err_next;
    end
  end

`ifdef ARB_FAIR_EN
  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= 3'd0;
    end else begin
      starve_reg <= starve_next;
    end
  end
`endif

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_type  = mem_type_reg;
  assign if_gnt    = if_gnt_reg;
  assign if_done   = if_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_gnt    = dm_gnt_reg;
  assign dm_done   = dm_done_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign dm_err    = dm_err_reg;
  assign stall_if  = if_req & ~if_done_reg;
  assign stall_mem = dm_req & ~dm_done_reg & ~dm_err_reg;

endmodule
